// File: rtl/mem_write_if.sv
// Processor data-memory write port, as seen by a passive monitor.
//   MemWrite   write strobe
//   DataAdr    write address
//   WriteData  write data
// master: the side driving the port (processor or bench).
// slave : the observer (mem_write_checker).
interface mem_write_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              MemWrite;
    logic [ADDR_W-1:0] DataAdr;
    logic [DATA_W-1:0] WriteData;

    modport master (output MemWrite, DataAdr, WriteData);
    modport slave  (input  MemWrite, DataAdr, WriteData);
endinterface

// File: rtl/mem_write_checker.sv
// mem_write_checker: compares observed memory writes against a preloaded
// table of expected (address, data) pairs, in order or in any order.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_we/idx/addr/data table load (ignored during a run or with start)
//   cfg_count           number of valid entries, latched on start
//   start               begin a run (ignored while running)
//   mw                  observed write port (slave modport)
//   busy                run in progress
//   pass / fail         sticky result of the last run
//   fail_code           0 none, 1 data mismatch, 2 unexpected address, 3 timeout
//   fail_addr/fail_data offending write (0 on timeout)
//   match_cnt           entries matched so far
module mem_write_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter bit ORDERED = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [DATA_W-1:0]          cfg_data,
    input  logic [$clog2(DEPTH):0]     cfg_count,
    input  logic                       start,
    mem_write_if.slave                 mw,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [ADDR_W-1:0]          fail_addr,
    output logic [DATA_W-1:0]          fail_data,
    output logic [$clog2(DEPTH):0]     match_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d, match_cnt_q, match_cnt_d;
    logic [TO_W-1:0]    cyc_q, cyc_d;
    logic [DEPTH-1:0]   matched_q, matched_d;
    logic               pass_q, pass_d, fail_q, fail_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]  fail_data_q, fail_data_d;
    logic [ADDR_W-1:0]  tab_addr_q [DEPTH];
    logic [ADDR_W-1:0]  tab_addr_d [DEPTH];
    logic [DATA_W-1:0]  tab_data_q [DEPTH];
    logic [DATA_W-1:0]  tab_data_d [DEPTH];

    // Candidate search for the current write.
    logic             hit_full, hit_addr;
    logic [IDX_W-1:0] hit_idx;

    always_comb begin
        hit_full = 1'b0;
        hit_addr = 1'b0;
        hit_idx  = '0;
        if (ORDERED) begin
            // Only the next entry in sequence may match; match_cnt < N in RUN.
            hit_idx  = match_cnt_q[IDX_W-1:0];
            hit_addr = (tab_addr_q[hit_idx] == mw.DataAdr);
            hit_full = hit_addr && (tab_data_q[hit_idx] == mw.WriteData);
        end else begin
            // Scan high to low so the lowest unmatched full match wins.
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if ((CNT_W'(i) < n_q) && !matched_q[i] &&
                    (tab_addr_q[i] == mw.DataAdr)) begin
                    hit_addr = 1'b1;
                    if (tab_data_q[i] == mw.WriteData) begin
                        hit_full = 1'b1;
                        hit_idx  = IDX_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        match_cnt_d = match_cnt_q;
        cyc_d       = cyc_q;
        matched_d   = matched_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_code_d = fail_code_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        tab_addr_d  = tab_addr_q;
        tab_data_d  = tab_data_q;
        unique case (state_q)
            RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (match_cnt_q == n_q) begin
                    // Only reachable with N=0: one RUN cycle, then PASS.
                    state_d = PASS;
                    pass_d  = 1'b1;
                end else if (mw.MemWrite && !hit_full) begin
                    state_d     = FAIL;
                    fail_d      = 1'b1;
                    fail_code_d = hit_addr ? 2'd1 : 2'd2;
                    fail_addr_d = mw.DataAdr;
                    fail_data_d = mw.WriteData;
                end else begin
                    if (mw.MemWrite) begin
                        match_cnt_d        = match_cnt_q + 1'b1;
                        matched_d[hit_idx] = 1'b1;
                    end
                    // A completing write beats a timeout on the same cycle.
                    if (match_cnt_d == n_q) begin
                        state_d = PASS;
                        pass_d  = 1'b1;
                    end else if (cyc_q == TO_W'(TIMEOUT - 1)) begin
                        state_d     = FAIL;
                        fail_d      = 1'b1;
                        fail_code_d = 2'd3;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d     = RUN;
                    n_d         = cfg_count;
                    match_cnt_d = '0;
                    cyc_d       = '0;
                    matched_d   = '0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_code_d = 2'd0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end else if (cfg_we) begin
                    tab_addr_d[cfg_idx] = cfg_addr;
                    tab_data_d[cfg_idx] = cfg_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            match_cnt_q <= '0;
            cyc_q       <= '0;
            matched_q   <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= 2'd0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            match_cnt_q <= match_cnt_d;
            cyc_q       <= cyc_d;
            matched_q   <= matched_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    // Table survives reset so it can be loaded once and reused.
    always_ff @(posedge clk) begin
        tab_addr_q <= tab_addr_d;
        tab_data_q <= tab_data_d;
    end

    assign busy      = (state_q == RUN);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign match_cnt = match_cnt_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Bench: an in-order checker (index 0) and an any-order checker (index 1)
// watch the same write port; a behavioural model of each is compared every cycle.
module tb_mem_write_checker;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset, cfg_we, start;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_addr, cfg_data;
    logic [3:0]  cfg_count;

    logic [1:0]  busy_o, pass_o, fail_o;
    logic [1:0]  code_o [2];
    logic [31:0] fa_o [2];
    logic [31:0] fd_o [2];
    logic [3:0]  mc_o [2];

    int n_chk = 0, n_fail = 0;

    mem_write_if #(.ADDR_W(32), .DATA_W(32)) mw ();

    always #5 clk = ~clk;

    mem_write_checker #(.DEPTH(8), .TIMEOUT(TO), .ORDERED(1'b1)) u_ord (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .start(start), .mw(mw.slave), .busy(busy_o[0]), .pass(pass_o[0]),
        .fail(fail_o[0]), .fail_code(code_o[0]), .fail_addr(fa_o[0]),
        .fail_data(fd_o[0]), .match_cnt(mc_o[0]));

    mem_write_checker #(.DEPTH(8), .TIMEOUT(TO), .ORDERED(1'b0)) u_any (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .start(start), .mw(mw.slave), .busy(busy_o[1]), .pass(pass_o[1]),
        .fail(fail_o[1]), .fail_code(code_o[1]), .fail_addr(fa_o[1]),
        .fail_data(fd_o[1]), .match_cnt(mc_o[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] t_a [2][8];
    logic [31:0] t_d [2][8];
    bit          m_run [2], m_pass [2], m_fail [2];
    int          m_code [2], m_cnt [2], m_n [2], m_age [2];
    logic [31:0] m_fa [2], m_fd [2];
    int          rem [$];   // unmatched entry indices (any-order checker), ascending

    always @(posedge clk) begin
        int  hit;
        bit  amatch;
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_run[m] = 0; m_pass[m] = 0; m_fail[m] = 0; m_code[m] = 0;
                m_cnt[m] = 0; m_n[m] = 0; m_age[m] = 0; m_fa[m] = 0; m_fd[m] = 0;
            end else if (m_run[m]) begin
                m_age[m]++;
                if (m_n[m] == 0) begin
                    m_run[m] = 0; m_pass[m] = 1;
                end else if (mw.MemWrite) begin
                    hit = -1; amatch = 0;
                    if (m == 0) begin
                        amatch = (mw.DataAdr == t_a[0][m_cnt[0]]);
                        if (amatch && mw.WriteData == t_d[0][m_cnt[0]]) hit = m_cnt[0];
                    end else begin
                        foreach (rem[j]) begin
                            if (t_a[1][rem[j]] == mw.DataAdr) begin
                                amatch = 1;
                                if (hit < 0 && t_d[1][rem[j]] == mw.WriteData) hit = j;
                            end
                        end
                        if (hit >= 0) rem.delete(hit);
                    end
                    if (hit >= 0) begin
                        m_cnt[m]++;
                        if (m_cnt[m] == m_n[m]) begin m_run[m] = 0; m_pass[m] = 1; end
                    end else begin
                        m_run[m] = 0; m_fail[m] = 1; m_code[m] = amatch ? 1 : 2;
                        m_fa[m] = mw.DataAdr; m_fd[m] = mw.WriteData;
                    end
                end
                if (m_run[m] && m_age[m] == TO) begin
                    m_run[m] = 0; m_fail[m] = 1; m_code[m] = 3; m_fa[m] = 0; m_fd[m] = 0;
                end
            end else if (start) begin
                m_run[m] = 1; m_n[m] = int'(cfg_count); m_cnt[m] = 0; m_age[m] = 0;
                m_pass[m] = 0; m_fail[m] = 0; m_code[m] = 0; m_fa[m] = 0; m_fd[m] = 0;
                if (m == 1) begin
                    rem.delete();
                    for (int k = 0; k < int'(cfg_count); k++) rem.push_back(k);
                end
            end else if (cfg_we) begin
                t_a[m][cfg_idx] = cfg_addr;
                t_d[m][cfg_idx] = cfg_data;
            end
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("busy[%0d]", m), 64'(busy_o[m]), 64'(m_run[m]));
            chk($sformatf("pass[%0d]", m), 64'(pass_o[m]), 64'(m_pass[m]));
            chk($sformatf("fail[%0d]", m), 64'(fail_o[m]), 64'(m_fail[m]));
            chk($sformatf("fail_code[%0d]", m), 64'(code_o[m]), 64'(m_code[m]));
            chk($sformatf("fail_addr[%0d]", m), 64'(fa_o[m]), 64'(m_fa[m]));
            chk($sformatf("fail_data[%0d]", m), 64'(fd_o[m]), 64'(m_fd[m]));
            chk($sformatf("match_cnt[%0d]", m), 64'(mc_o[m]), 64'(m_cnt[m]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic go(input int n);
        start = 1; cfg_count = 4'(n);
        tick();
        start = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mw.MemWrite = 1; mw.DataAdr = a; mw.WriteData = d;
        tick();
        mw.MemWrite = 0; mw.DataAdr = 0; mw.WriteData = 0;
    endtask

    initial begin
        reset = 1; cfg_we = 0; start = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0;
        cfg_count = 0; mw.MemWrite = 0; mw.DataAdr = 0; mw.WriteData = 0;
        tick(2);
        reset = 0;
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset pass/fail", 64'({pass_o, fail_o}), 64'd0);
        chk("reset match_cnt", 64'(mc_o[0]), 64'd0);

        // in-order pass, N=1
        cfg(0, 100, 7);
        go(1);
        wr(100, 7);
        chk("ord pass", 64'({pass_o[0], busy_o[0], mc_o[0]}), {44'd0, 1'b1, 1'b0, 4'd1});

        // data mismatch
        go(1);
        wr(100, 8);
        chk("mismatch code", 64'(code_o[0]), 64'd1);
        chk("mismatch addr/data", {fa_o[1], fd_o[1]}, {32'd100, 32'd8});

        // ordering violation vs any order
        cfg(0, 96, 1);
        cfg(1, 100, 7);
        go(2);
        wr(100, 7);
        chk("order viol code", 64'(code_o[0]), 64'd2);
        chk("any busy after 1", 64'({busy_o[1], mc_o[1]}), {59'd0, 1'b1, 4'd1});
        wr(96, 1);
        chk("any pass", 64'({pass_o[1], mc_o[1]}), {59'd0, 1'b1, 4'd2});
        chk("ord stays failed", 64'({fail_o[0], code_o[0]}), {61'd0, 1'b1, 2'd2});

        // repeat of an already-matched write
        go(2);
        wr(96, 1);
        wr(96, 1);
        chk("repeat code", 64'({code_o[1], code_o[0]}), {60'd0, 2'd2, 2'd2});

        // timeout: fail appears exactly TO cycles after start
        cfg(0, 100, 7);
        go(1);
        tick(TO - 1);
        chk("no timeout yet", 64'(fail_o), 64'd0);
        tick();
        chk("timeout", 64'({fail_o[0], code_o[0], fa_o[0]}), {29'd0, 1'b1, 2'd3, 32'd0});

        // matching write on the last allowed cycle beats timeout
        go(1);
        tick(TO - 1);
        wr(100, 7);
        chk("late pass", 64'(pass_o), 64'd3);

        // sticky pass; ignored writes; cfg while idle takes effect
        wr(0, 0);
        cfg(0, 200, 5);
        chk("sticky pass", 64'(pass_o), 64'd3);
        cfg_we = 1; cfg_idx = 0; cfg_addr = 300; cfg_data = 3;  // same cycle as start: ignored
        go(1);
        cfg_we = 0;
        chk("restart", 64'({pass_o, busy_o}), {60'd0, 2'd0, 2'd3});
        cfg(0, 400, 4);                                         // during run: ignored
        wr(200, 5);
        chk("cfg took effect", 64'(pass_o), 64'd3);

        // write at the timeout cycle with wrong data: mismatch wins over timeout
        go(1);
        tick(TO - 1);
        wr(200, 6);
        chk("mismatch over timeout", 64'({code_o[0], code_o[1]}), 64'h5);

        // reset mid-run, then N=0
        go(2);
        tick(2);
        reset = 1;
        tick();
        reset = 0;
        chk("mid reset", 64'({busy_o, pass_o, fail_o, mc_o[0]}), 64'd0);
        go(0);
        chk("n0 busy", 64'(busy_o), 64'd3);
        tick();
        chk("n0 pass", 64'({pass_o, busy_o}), {60'd0, 2'd3, 2'd0});

        tick(2);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
